// File: rtl/light_pkg.sv
// Shared definitions for the pedestrian button conditioner and the light sequencer:
// request FSM state encoding and default timing constants.
package light_pkg;

  typedef logic [1:0] light_state_t;

  localparam light_state_t IDLE    = 2'd0;
  localparam light_state_t PENDING = 2'd1;
  localparam light_state_t HOLD    = 2'd2;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/ped_button_conditioner_btn_debounce.sv
// Two-flop synchroniser, stability-counting debouncer and registered press strobe.
// btn_level_o changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic press_pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Pulse fires in the first cycle the new level is visible, rising edges only.
      level_d = s2_q;
      cnt_d   = '0;
      pulse_d = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level_o   = level_q;
  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian button conditioner: debounced press latched into a request held until req_ack.
// Optional self-clearing request timer is enabled by defining REQ_TIMEOUT_EN.
// Handshake: req is a level; the sequencer accepts it with a 1-cycle req_ack strobe,
// and req drops in the following cycle. req_ack outside PENDING has no effect.
module ped_button_conditioner
  import light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic              req_ack,
  output logic              req,
  output logic              btn_level,
  output logic              press_pulse,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              req_timeout,
  output logic [1:0]        fsm_state_o
);

  light_state_t      state_q, state_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              req_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .btn_raw_i    (btn_raw),
    .btn_level_o  (btn_level),
    .press_pulse_o(press_pulse)
  );

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
`ifdef REQ_TIMEOUT_EN
    timeout_d = 1'b0;
    // Counting only while PENDING means the timer is always zero on entry.
    timer_d   = (state_q == PENDING) ? timer_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (press_pulse) state_d = PENDING;
      end
      PENDING: begin
        if (press_pulse && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + 1'b1;
        if (req_ack) begin
          state_d = HOLD;
`ifdef REQ_TIMEOUT_EN
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (!btn_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= '0;
      req_q   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      req_q   <= (state_d == PENDING);
`ifdef REQ_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign req         = req_q;
  assign drop_cnt    = drop_q;
  assign fsm_state_o = state_q;
`ifdef REQ_TIMEOUT_EN
  assign req_timeout = timeout_q;
`else
  assign req_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Directed bench for ped_button_conditioner with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_ped_button_conditioner;
  import light_pkg::*;

  logic       clk = 1'b0;
  logic       reset, btn_raw, req_ack;
  logic       req, btn_level, press_pulse, req_timeout;
  logic [7:0] drop_cnt;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  ped_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (8),
    .DROP_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .req_ack    (req_ack),
    .req        (req),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .drop_cnt   (drop_cnt),
    .req_timeout(req_timeout),
    .fsm_state_o(fsm_state)
  );

  typedef struct {
    logic       rst;
    logic       raw;
    logic       ack;
    logic       lvl;
    logic       pls;
    logic       rq;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic rst, input logic raw, input logic ack,
                         input logic lvl, input logic pls, input logic rq,
                         input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.raw = raw; v.ack = ack;
    v.lvl = lvl; v.pls = pls; v.rq = rq; v.st = st;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_release();
    btn_raw = 1'b0;
    repeat (8) step();
    btn_raw = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    btn_raw = 1'b1;
    req_ack = 1'b0;

    // Reset with button held, release, debounce, handshake, release into IDLE.
    for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IDLE);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PENDING);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, HOLD);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, HOLD);
    for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, HOLD);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HOLD);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

    for (int i = 0; i < vq.size(); i++) begin
      reset   = vq[i].rst;
      btn_raw = vq[i].raw;
      req_ack = vq[i].ack;
      step();
      check($sformatf("vec%0d_level", i), btn_level, vq[i].lvl);
      check($sformatf("vec%0d_pulse", i), press_pulse, vq[i].pls);
      check($sformatf("vec%0d_req", i), req, vq[i].rq);
      check($sformatf("vec%0d_state", i), fsm_state, vq[i].st);
      check($sformatf("vec%0d_drop", i), drop_cnt, 0);
      check($sformatf("vec%0d_timeout", i), req_timeout, 0);
    end
    req_ack = 1'b0;

    // Bounce: 1,0,1,0 then steady 1; level rises on the 6th edge after the steady edge.
    pulses = 0;
    btn_raw = 1'b1; step(); pulses += int'(press_pulse);
    btn_raw = 1'b0; step(); pulses += int'(press_pulse);
    btn_raw = 1'b1; step(); pulses += int'(press_pulse);
    btn_raw = 1'b0; step(); pulses += int'(press_pulse);
    btn_raw = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      pulses += int'(press_pulse);
      check($sformatf("bounce_level_early%0d", k), btn_level, 0);
    end
    step();
    pulses += int'(press_pulse);
    check("bounce_level_rise", btn_level, 1);
    check("bounce_pulse", press_pulse, 1);
    step();
    pulses += int'(press_pulse);
    check("bounce_pulse_count", pulses, 1);
    check("bounce_req", req, 1);
    check("bounce_state", fsm_state, PENDING);

`ifdef REQ_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("to_req_held%0d", k), req, 1);
      check($sformatf("to_strobe_low%0d", k), req_timeout, 0);
    end
    step();
    check("to_req_dropped", req, 0);
    check("to_strobe", req_timeout, 1);
    check("to_state", fsm_state, IDLE);
    step();
    check("to_strobe_single", req_timeout, 0);
`else
    // Busy drops while PENDING.
    for (int k = 1; k <= 3; k++) begin
      press_release();
      check($sformatf("drop_cnt%0d", k), drop_cnt, k);
      check($sformatf("drop_req%0d", k), req, 1);
    end

    // Collision: press_pulse and req_ack sampled on the same edge.
    btn_raw = 1'b0;
    repeat (8) step();
    check("coll_released", btn_level, 0);
    btn_raw = 1'b1;
    repeat (5) step();
    check("coll_no_pulse_yet", press_pulse, 0);
    step();
    check("coll_pulse", press_pulse, 1);
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    check("coll_state", fsm_state, HOLD);
    check("coll_req", req, 0);
    check("coll_drop", drop_cnt, 4);

    btn_raw = 1'b0;
    repeat (6) step();
    check("hold_level_fell", btn_level, 0);
    check("hold_still", fsm_state, HOLD);
    step();
    check("hold_to_idle", fsm_state, IDLE);
    btn_raw = 1'b1;
    repeat (7) step();
    check("repress_state", fsm_state, PENDING);
    check("repress_req", req, 1);

    // Saturation: 4 + 250 + 6 = 260 drops, counter stops at 255.
    repeat (250) press_release();
    check("drop_254", drop_cnt, 254);
    repeat (6) press_release();
    check("drop_sat", drop_cnt, 255);

    repeat (100) step();
    check("no_timeout_req", req, 1);
    check("no_timeout_state", fsm_state, PENDING);
    check("no_timeout_strobe", req_timeout, 0);
`endif

    // Reset mid-request drops req without an ack.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_req", req, 0);
    check("midreset_state", fsm_state, IDLE);
    check("midreset_drop", drop_cnt, 0);
    check("midreset_level", btn_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

endmodule
